// File: rtl/ps2_command_tx.sv
`timescale 1ns / 1ps
// ps2_command_tx: host-to-device PS/2 command transmitter.
// Inhibits the bus, issues a request-to-send, shifts one byte plus odd parity
// out on device-generated clock falls, then checks the device acknowledge.
// Lines are open-drain: *_oe = 1 pulls the corresponding pad low.
module ps2_command_tx #(
  parameter int INHIBIT_CYCLES       = 6000,
  parameter int START_TIMEOUT_CYCLES = 750000,
  parameter int XFER_TIMEOUT_CYCLES  = 100000,
  parameter int FILTER_CYCLES        = 8
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] the_command,
  input  logic       send_command,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       clk_oe,
  output logic       dat_oe,
  output logic       busy,
  output logic       command_was_sent,
  output logic       error_communication_timed_out,
  output logic       error_no_ack
);

  // One shared cycle counter covers inhibit, start timeout and transfer timeout,
  // since those phases never overlap; size it for the largest of the three.
  localparam int MAX_AB  = (INHIBIT_CYCLES > START_TIMEOUT_CYCLES) ? INHIBIT_CYCLES : START_TIMEOUT_CYCLES;
  localparam int MAX_CYC = (MAX_AB > XFER_TIMEOUT_CYCLES) ? MAX_AB : XFER_TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int FLT_W   = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;

  localparam logic [CNT_W-1:0] CNT_MAX      = '1;
  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] START_LAST   = CNT_W'(START_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] XFER_LAST    = CNT_W'(XFER_TIMEOUT_CYCLES - 1);
  localparam logic [FLT_W-1:0] FLT_LAST     = FLT_W'(FILTER_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE, INHIBIT, REQ, WAIT_START, XFER, ACK, WAIT_IDLE, ERR_TO, ERR_NACK
  } state_t;

  // Input conditioning: bit 0 = PS2_CLK, bit 1 = PS2_DAT
  logic [1:0]       sync1_reg, sync2_reg;
  logic             clk_sync, dat_sync;
  logic             filt_clk_reg;
  logic [FLT_W-1:0] filt_cnt_reg;
  logic             fall_reg;

  // Control state
  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [3:0]       bitcnt_reg, bitcnt_next;
  logic [7:0]       cmd_reg, cmd_next;
  logic             par_reg, par_next;

  // Registered outputs
  logic clk_oe_reg, clk_oe_next;
  logic dat_oe_reg, dat_oe_next;
  logic busy_reg, busy_next;
  logic sent_reg, sent_next;
  logic to_reg, to_next;
  logic nack_reg, nack_next;

  assign clk_sync = sync2_reg[0];
  assign dat_sync = sync2_reg[1];

  // Two-flop synchronisers; idle bus level is high
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync1_reg <= 2'b11;
      sync2_reg <= 2'b11;
    end else begin
      sync1_reg <= {ps2_dat_in, ps2_clk_in};
      sync2_reg <= sync1_reg;
    end
  end

  // Glitch filter: the clock level only follows after FILTER_CYCLES equal samples
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      filt_clk_reg <= 1'b1;
      filt_cnt_reg <= '0;
      fall_reg     <= 1'b0;
    end else begin
      fall_reg <= 1'b0;
      if (clk_sync == filt_clk_reg) begin
        filt_cnt_reg <= '0;
      end else if (filt_cnt_reg == FLT_LAST) begin
        filt_clk_reg <= clk_sync;
        filt_cnt_reg <= '0;
        fall_reg     <= ~clk_sync;
      end else begin
        filt_cnt_reg <= filt_cnt_reg + 1'b1;
      end
    end
  end

  // State, datapath and output registers
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      bitcnt_reg <= '0;
      cmd_reg    <= '0;
      par_reg    <= 1'b0;
      clk_oe_reg <= 1'b0;
      dat_oe_reg <= 1'b0;
      busy_reg   <= 1'b0;
      sent_reg   <= 1'b0;
      to_reg     <= 1'b0;
      nack_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      bitcnt_reg <= bitcnt_next;
      cmd_reg    <= cmd_next;
      par_reg    <= par_next;
      clk_oe_reg <= clk_oe_next;
      dat_oe_reg <= dat_oe_next;
      busy_reg   <= busy_next;
      sent_reg   <= sent_next;
      to_reg     <= to_next;
      nack_reg   <= nack_next;
    end
  end

  // Next-state and next-output logic; outputs are decoded from the next state
  // so every output is a flop and the pulses coincide with busy dropping.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;
    bitcnt_next = bitcnt_reg;
    cmd_next    = cmd_reg;
    par_next    = par_reg;
    dat_oe_next = dat_oe_reg;
    sent_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (send_command) begin
          cmd_next   = the_command;
          par_next   = ~^the_command;
          state_next = INHIBIT;
        end
      end
      INHIBIT: begin
        if (cnt_reg == INHIBIT_LAST) begin
          state_next  = REQ;
          cnt_next    = '0;
          dat_oe_next = 1'b1;
        end
      end
      REQ: begin
        state_next = WAIT_START;
        cnt_next   = '0;
      end
      WAIT_START: begin
        if (fall_reg) begin
          dat_oe_next = ~cmd_reg[0];
          bitcnt_next = 4'd1;
          cnt_next    = '0;
          state_next  = XFER;
        end else if (cnt_reg == START_LAST) begin
          state_next = ERR_TO;
        end
      end
      XFER: begin
        if (fall_reg) begin
          bitcnt_next = bitcnt_reg + 4'd1;
          if (bitcnt_reg <= 4'd7) begin
            dat_oe_next = ~cmd_reg[bitcnt_reg[2:0]];
          end else if (bitcnt_reg == 4'd8) begin
            dat_oe_next = ~par_reg;
          end else begin
            // Releasing DAT drives the stop bit high
            dat_oe_next = 1'b0;
            state_next  = ACK;
          end
        end else if (cnt_reg == XFER_LAST) begin
          state_next = ERR_TO;
        end
      end
      ACK: begin
        if (fall_reg) begin
          state_next = dat_sync ? ERR_NACK : WAIT_IDLE;
        end else if (cnt_reg == XFER_LAST) begin
          state_next = ERR_TO;
        end
      end
      WAIT_IDLE: begin
        if (filt_clk_reg && dat_sync) begin
          sent_next  = 1'b1;
          state_next = IDLE;
        end else if (cnt_reg == XFER_LAST) begin
          state_next = ERR_TO;
        end
      end
      ERR_TO:   state_next = IDLE;
      ERR_NACK: state_next = IDLE;
      default:  state_next = IDLE;
    endcase

    // DAT is only ever pulled while requesting or shifting bits out
    if (!(state_next inside {REQ, WAIT_START, XFER})) begin
      dat_oe_next = 1'b0;
    end

    clk_oe_next = (state_next == INHIBIT) || (state_next == REQ);
    busy_next   = !(state_next inside {IDLE, ERR_TO, ERR_NACK});
    to_next     = (state_next == ERR_TO);
    nack_next   = (state_next == ERR_NACK);
  end

  assign clk_oe                        = clk_oe_reg;
  assign dat_oe                        = dat_oe_reg;
  assign busy                          = busy_reg;
  assign command_was_sent              = sent_reg;
  assign error_communication_timed_out = to_reg;
  assign error_no_ack                  = nack_reg;

endmodule

// File: tb/tb_ps2_command_tx.sv
`timescale 1ns / 1ps
// Directed bench for ps2_command_tx with a simple PS/2 device model.
module tb_ps2_command_tx;

  localparam int INH      = 20;
  localparam int START_TO = 2000;
  localparam int XFER_TO  = 5000;
  localparam int FILT     = 2;
  localparam int HALF     = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] the_command;
  logic       send_command;
  logic       clk_oe, dat_oe, busy;
  logic       command_was_sent, error_communication_timed_out, error_no_ack;
  logic       dev_clk, dev_dat;

  // Open-drain bus: low if either side pulls
  wire clk_line = ~clk_oe & dev_clk;
  wire dat_line = ~dat_oe & dev_dat;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int sent_cnt = 0;
  int to_cnt   = 0;
  int nack_cnt = 0;

  ps2_command_tx #(
    .INHIBIT_CYCLES(INH),
    .START_TIMEOUT_CYCLES(START_TO),
    .XFER_TIMEOUT_CYCLES(XFER_TO),
    .FILTER_CYCLES(FILT)
  ) dut (
    .CLOCK_50(clk),
    .reset(reset),
    .the_command(the_command),
    .send_command(send_command),
    .ps2_clk_in(clk_line),
    .ps2_dat_in(dat_line),
    .clk_oe(clk_oe),
    .dat_oe(dat_oe),
    .busy(busy),
    .command_was_sent(command_was_sent),
    .error_communication_timed_out(error_communication_timed_out),
    .error_no_ack(error_no_ack)
  );

  always #10 clk = ~clk;

  // Free-running cycle stamp
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse counters sampled away from the active edge
  always @(negedge clk) begin
    if (command_was_sent === 1'b1) sent_cnt <= sent_cnt + 1;
    if (error_communication_timed_out === 1'b1) to_cnt <= to_cnt + 1;
    if (error_no_ack === 1'b1) nack_cnt <= nack_cnt + 1;
  end

  task automatic send_cmd(input logic [7:0] c);
    @(negedge clk);
    the_command  = c;
    send_command = 1'b1;
    @(negedge clk);
    send_command = 1'b0;
  endtask

  // Device model: waits for the request, then clocks n_falls falling edges,
  // sampling what the host drives while the clock is low.
  task automatic bfm(input int n_falls, input bit do_ack, input int glitch_at,
                     output logic [10:0] bits, output int t_xfer);
    int n;
    bits   = '0;
    t_xfer = 0;
    n      = 0;
    while (!(clk_oe === 1'b0 && dat_oe === 1'b1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n >= 200) begin
      n_fail++;
      $display("FAIL bfm_start: clk_oe=%b dat_oe=%b, required 0/1 within 200 cycles", clk_oe, dat_oe);
    end else begin
      for (int i = 1; i <= n_falls; i++) begin
        if (i == 11 && do_ack) dev_dat = 1'b0;
        for (int k = 0; k < HALF; k++) begin
          @(negedge clk);
          if (k == HALF / 2 && i == glitch_at) begin
            dev_clk = 1'b0;
            @(negedge clk);
            dev_clk = 1'b1;
          end
        end
        if (i == 1) bits[0] = dat_line;
        dev_clk = 1'b0;
        for (int k = 0; k < HALF; k++) begin
          @(negedge clk);
          if (i == 1 && t_xfer == 0 && dat_oe === 1'b0) t_xfer = cyc;
        end
        if (i <= 10) bits[i] = dat_line;
        dev_clk = 1'b1;
      end
      for (int k = 0; k < HALF; k++) @(negedge clk);
      dev_dat = 1'b1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({clk_oe, dat_oe, busy, command_was_sent, error_communication_timed_out, error_no_ack} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required 000000",
               {clk_oe, dat_oe, busy, command_was_sent, error_communication_timed_out, error_no_ack});
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if ({clk_oe, dat_oe, busy} !== 3'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %b required 000", {clk_oe, dat_oe, busy});
    end
  endtask

  task automatic test_idle_traffic;
    int s0, t0, k0, bsy;
    s0 = sent_cnt; t0 = to_cnt; k0 = nack_cnt; bsy = 0;
    repeat (3) begin
      dev_clk = 1'b0;
      repeat (HALF) begin @(negedge clk); if (busy !== 1'b0 || clk_oe !== 1'b0) bsy++; end
      dev_clk = 1'b1;
      repeat (HALF) begin @(negedge clk); if (busy !== 1'b0 || clk_oe !== 1'b0) bsy++; end
    end
    n_checks++;
    if (bsy != 0 || sent_cnt != s0 || to_cnt != t0 || nack_cnt != k0) begin
      n_fail++;
      $display("FAIL idle_traffic: active cycles=%0d pulses=%0d/%0d/%0d required 0",
               bsy, sent_cnt - s0, to_cnt - t0, nack_cnt - k0);
    end
    $display("idle traffic: 3 device clocks ignored");
  endtask

  task automatic test_send_ed;
    int s0, t0, k0, n, tx;
    logic [10:0] bits;
    s0 = sent_cnt; t0 = to_cnt; k0 = nack_cnt;
    send_cmd(8'hED);
    n = 0;
    while (clk_oe === 1'b1 && dat_oe === 1'b0 && n < 100) begin n++; @(negedge clk); end
    n_checks++;
    if (n != 20) begin n_fail++; $display("FAIL inhibit_len: got %0d cycles required 20", n); end
    n_checks++;
    if ({clk_oe, dat_oe} !== 2'b11) begin
      n_fail++; $display("FAIL req_cycle: clk_oe,dat_oe=%b required 11", {clk_oe, dat_oe});
    end
    @(negedge clk);
    n_checks++;
    if ({clk_oe, dat_oe, busy} !== 3'b011) begin
      n_fail++; $display("FAIL wait_start: clk_oe,dat_oe,busy=%b required 011", {clk_oe, dat_oe, busy});
    end
    bfm(11, 1'b1, 0, bits, tx);
    n_checks++;
    if (bits !== 11'b1_1_11101101_0) begin
      n_fail++; $display("FAIL bits_ed: got %b required %b", bits, 11'b1_1_11101101_0);
    end
    repeat (40) @(negedge clk);
    n_checks++;
    if (sent_cnt - s0 != 1 || to_cnt != t0 || nack_cnt != k0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL result_ed: sent/to/nack=%0d/%0d/%0d busy=%b required 1/0/0 busy 0",
               sent_cnt - s0, to_cnt - t0, nack_cnt - k0, busy);
    end
    $display("send 0xED: bits=%b sent=%0d", bits, sent_cnt - s0);
  endtask

  task automatic test_start_timeout;
    int s0, k0, t0, n, t_rel;
    s0 = sent_cnt; k0 = nack_cnt; t0 = to_cnt;
    send_cmd(8'hED);
    n = 0;
    while (clk_oe !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    t_rel = cyc;
    n = 0;
    while (error_communication_timed_out !== 1'b1 && n < 2100) begin @(negedge clk); n++; end
    n_checks++;
    if (cyc - t_rel != 2000) begin
      n_fail++; $display("FAIL start_timeout_time: got %0d cycles required 2000", cyc - t_rel);
    end
    n_checks++;
    if ({clk_oe, dat_oe, busy} !== 3'b000) begin
      n_fail++; $display("FAIL start_timeout_lines: clk_oe,dat_oe,busy=%b required 000", {clk_oe, dat_oe, busy});
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (to_cnt - t0 != 1 || sent_cnt != s0 || nack_cnt != k0) begin
      n_fail++;
      $display("FAIL start_timeout_pulses: to/sent/nack=%0d/%0d/%0d required 1/0/0",
               to_cnt - t0, sent_cnt - s0, nack_cnt - k0);
    end
    $display("send 0xED, silent device: timeout after %0d cycles", cyc - t_rel - 5);
  endtask

  task automatic test_no_ack;
    int s0, k0, t0, tx;
    logic [10:0] bits;
    s0 = sent_cnt; k0 = nack_cnt; t0 = to_cnt;
    send_cmd(8'hED);
    bfm(11, 1'b0, 0, bits, tx);
    repeat (40) @(negedge clk);
    n_checks++;
    if (nack_cnt - k0 != 1 || sent_cnt != s0 || to_cnt != t0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL no_ack: nack/sent/to=%0d/%0d/%0d busy=%b required 1/0/0 busy 0",
               nack_cnt - k0, sent_cnt - s0, to_cnt - t0, busy);
    end
    $display("send 0xED, no ack: nack=%0d", nack_cnt - k0);
  endtask

  task automatic test_xfer_timeout;
    int s0, t0, n, tx;
    logic [10:0] bits;
    s0 = sent_cnt; t0 = to_cnt;
    send_cmd(8'hED);
    bfm(5, 1'b1, 0, bits, tx);
    n = 0;
    while (error_communication_timed_out !== 1'b1 && n < 6000) begin @(negedge clk); n++; end
    n_checks++;
    if (tx == 0 || cyc - tx != 5000) begin
      n_fail++; $display("FAIL xfer_timeout_time: got %0d cycles required 5000", cyc - tx);
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (to_cnt - t0 != 1 || sent_cnt != s0 || {clk_oe, dat_oe, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL xfer_timeout_result: to=%0d sent=%0d lines/busy=%b required 1 0 000",
               to_cnt - t0, sent_cnt - s0, {clk_oe, dat_oe, busy});
    end
    $display("send 0xED, stall after 5 edges: timeout pulses=%0d", to_cnt - t0);
  endtask

  task automatic test_reset_mid;
    int s0, t0, k0, tx;
    logic [10:0] bits;
    s0 = sent_cnt; t0 = to_cnt; k0 = nack_cnt;
    send_cmd(8'hED);
    bfm(4, 1'b1, 0, bits, tx);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b required 1", busy); end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({clk_oe, dat_oe, busy, command_was_sent, error_communication_timed_out, error_no_ack} !== 6'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got %b required 000000",
               {clk_oe, dat_oe, busy, command_was_sent, error_communication_timed_out, error_no_ack});
    end
    reset = 1'b0;
    repeat (20) @(negedge clk);
    n_checks++;
    if (sent_cnt != s0 || to_cnt != t0 || nack_cnt != k0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_quiet: pulses=%0d/%0d/%0d busy=%b required none",
               sent_cnt - s0, to_cnt - t0, nack_cnt - k0, busy);
    end
    send_cmd(8'hFF);
    bfm(11, 1'b1, 0, bits, tx);
    n_checks++;
    if (bits !== 11'b1_1_11111111_0) begin
      n_fail++; $display("FAIL bits_ff: got %b required %b", bits, 11'b1_1_11111111_0);
    end
    repeat (40) @(negedge clk);
    n_checks++;
    if (sent_cnt - s0 != 1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL result_ff: sent=%0d busy=%b required 1 busy 0", sent_cnt - s0, busy);
    end
    $display("reset mid 0xED, then send 0xFF: bits=%b sent=%0d", bits, sent_cnt - s0);
  endtask

  task automatic test_glitch_and_ignore;
    int s0, t0, k0, tx;
    logic [10:0] bits;
    s0 = sent_cnt; t0 = to_cnt; k0 = nack_cnt;
    send_cmd(8'h5B);
    repeat (5) @(negedge clk);
    the_command  = 8'h00;
    send_command = 1'b1;
    @(negedge clk);
    send_command = 1'b0;
    bfm(11, 1'b1, 5, bits, tx);
    n_checks++;
    if (bits !== 11'b1_0_01011011_0) begin
      n_fail++; $display("FAIL bits_5b_glitch: got %b required %b", bits, 11'b1_0_01011011_0);
    end
    repeat (40) @(negedge clk);
    n_checks++;
    if (sent_cnt - s0 != 1 || to_cnt != t0 || nack_cnt != k0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL result_5b: sent/to/nack=%0d/%0d/%0d busy=%b required 1/0/0 busy 0",
               sent_cnt - s0, to_cnt - t0, nack_cnt - k0, busy);
    end
    $display("send 0x5B with glitch and ignored 0x00 request: bits=%b sent=%0d", bits, sent_cnt - s0);
  endtask

  initial begin
    reset        = 1'b1;
    send_command = 1'b0;
    the_command  = 8'h00;
    dev_clk      = 1'b1;
    dev_dat      = 1'b1;
    test_reset;
    test_idle_traffic;
    test_send_ed;
    test_start_timeout;
    test_no_ack;
    test_xfer_timeout;
    test_reset_mid;
    test_glitch_and_ignore;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
